// File: rtl/result_buffer_pkg.sv
// Shared types and sizes for the result buffer and its flush controller.
package VSTypes;
  localparam int RB_SIZE   = 16;
  localparam int RB_IDX_W  = 4;
  localparam int RB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } RBStateType;

  typedef struct packed {
    logic [RB_DATA_W-1:0] data;
    logic                 valid;
  } RBReadRespType;
endpackage

// File: rtl/result_buffer_if.sv
// Bus bundle of the result buffer: writeback, invalidate, two read ports,
// valid vector, count and flush handshake. master drives, slave is the buffer.
interface result_buffer_if #(
  parameter int RB_DEPTH   = VSTypes::RB_SIZE,
  parameter int DATA_WIDTH = VSTypes::RB_DATA_W
);
  localparam int IW = $clog2(RB_DEPTH);
  localparam int CW = IW + 1;

  logic                  WrEnIn;
  logic [IW-1:0]         WrIdxIn;
  logic [DATA_WIDTH-1:0] WrDataIn;
  logic                  InvEnIn;
  logic [IW-1:0]         InvIdxIn;
  logic                  rs1_RB_ReadEn;
  logic [IW-1:0]         rs1_RB_IdxIn;
  logic                  rs2_RB_ReadEn;
  logic [IW-1:0]         rs2_RB_IdxIn;
  logic [DATA_WIDTH-1:0] Rd1DataOut;
  logic                  Rd1ValidOut;
  logic [DATA_WIDTH-1:0] Rd2DataOut;
  logic                  Rd2ValidOut;
  logic [RB_DEPTH-1:0]   RB_ValidOut;
  logic                  FlushReqIn;
  logic                  BusyOut;
  logic                  FlushDoneOut;
  logic [CW-1:0]         CountOut;

  modport master (
    output WrEnIn, WrIdxIn, WrDataIn, InvEnIn, InvIdxIn,
           rs1_RB_ReadEn, rs1_RB_IdxIn, rs2_RB_ReadEn, rs2_RB_IdxIn, FlushReqIn,
    input  Rd1DataOut, Rd1ValidOut, Rd2DataOut, Rd2ValidOut,
           RB_ValidOut, BusyOut, FlushDoneOut, CountOut
  );

  modport slave (
    input  WrEnIn, WrIdxIn, WrDataIn, InvEnIn, InvIdxIn,
           rs1_RB_ReadEn, rs1_RB_IdxIn, rs2_RB_ReadEn, rs2_RB_IdxIn, FlushReqIn,
    output Rd1DataOut, Rd1ValidOut, Rd2DataOut, Rd2ValidOut,
           RB_ValidOut, BusyOut, FlushDoneOut, CountOut
  );
endinterface

// File: rtl/result_buffer_flush_ctrl.sv
// Flush sequencer: walks cnt over every entry (one clear per cycle),
// then spends one cycle in DONE before returning to IDLE.
module rb_flush_ctrl import VSTypes::*; #(
  parameter  int DEPTH = RB_SIZE,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_req,
  output RBStateType    state,
  output logic [IW-1:0] cnt,
  output logic          clr_en,
  output logic          busy,
  output logic          done
);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  RBStateType    r_state;
  logic [IW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;

  // State, entry counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (flush_req) begin
          r_state <= FLUSH;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
        FLUSH: begin
          r_cnt <= r_cnt + IW'(1);
          if (r_cnt == LAST) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign state  = r_state;
  assign cnt    = r_cnt;
  assign clr_en = (r_state == FLUSH);
  assign busy   = r_busy;
  assign done   = r_done;
endmodule

// File: rtl/result_buffer.sv
// Result buffer: RB_DEPTH reusable results with per-entry valid bits,
// two registered read ports, a live-entry count and a sequenced flush.
// Optional feature: define RB_WR_BYPASS_EN to forward a same-cycle write
// to a read of the same index.
module result_buffer import VSTypes::*; #(
  parameter int RB_DEPTH   = RB_SIZE,
  parameter int DATA_WIDTH = RB_DATA_W
) (
  input logic           ClockIn,
  input logic           ResetIn,
  result_buffer_if.slave bus
);
  localparam int IW = $clog2(RB_DEPTH);
  localparam int CW = IW + 1;
`ifdef RB_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] r_data [RB_DEPTH];
  logic [RB_DEPTH-1:0]   r_valid;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_rd_data [2];
  logic                  r_rd_vld  [2];

  RBStateType    w_state;
  logic [IW-1:0] w_cnt;
  logic          w_clr_en, w_busy, w_done, w_idle;
  logic          w_wr, w_inv, w_inc, w_dec;
  logic          w_ren  [2];
  logic [IW-1:0] w_ridx [2];

  rb_flush_ctrl #(.DEPTH(RB_DEPTH)) u_ctrl (
    .clk(ClockIn), .rst(ResetIn), .flush_req(bus.FlushReqIn),
    .state(w_state), .cnt(w_cnt), .clr_en(w_clr_en),
    .busy(w_busy), .done(w_done)
  );

  // Updates are only accepted while idle; FLUSH and DONE drop them.
  assign w_idle    = (w_state == IDLE);
  assign w_wr      = bus.WrEnIn  & w_idle;
  assign w_inv     = bus.InvEnIn & w_idle;
  assign w_ren[0]  = bus.rs1_RB_ReadEn;
  assign w_ren[1]  = bus.rs2_RB_ReadEn;
  assign w_ridx[0] = bus.rs1_RB_IdxIn;
  assign w_ridx[1] = bus.rs2_RB_IdxIn;

  // Count deltas: a same-index write cancels the invalidate's decrement.
  assign w_inc = w_wr & ~r_valid[bus.WrIdxIn];
  assign w_dec = (w_inv & r_valid[bus.InvIdxIn] &
                  ~(w_wr & (bus.WrIdxIn == bus.InvIdxIn))) |
                 (w_clr_en & r_valid[w_cnt]);

  // Data storage; deliberately not reset.
  always_ff @(posedge ClockIn) begin
    if (w_wr) r_data[bus.WrIdxIn] <= bus.WrDataIn;
  end

  // Valid bits; the write is applied last so it wins over an invalidate.
  always_ff @(posedge ClockIn) begin
    if (ResetIn) begin
      r_valid <= '0;
    end else begin
      if (w_clr_en) r_valid[w_cnt]        <= 1'b0;
      if (w_inv)    r_valid[bus.InvIdxIn] <= 1'b0;
      if (w_wr)     r_valid[bus.WrIdxIn]  <= 1'b1;
    end
  end

  // Live-entry count, saturating at both ends.
  always_ff @(posedge ClockIn) begin
    if (ResetIn)
      r_count <= '0;
    else if (w_inc && !w_dec && r_count != CW'(RB_DEPTH))
      r_count <= r_count + CW'(1);
    else if (w_dec && !w_inc && r_count != '0)
      r_count <= r_count - CW'(1);
  end

  // Registered read ports; data holds when the port is not enabled.
  always_ff @(posedge ClockIn) begin
    for (int p = 0; p < 2; p++) begin
      if (ResetIn) begin
        r_rd_data[p] <= '0;
        r_rd_vld[p]  <= 1'b0;
      end else if (w_ren[p]) begin
        if (BYPASS && w_wr && (bus.WrIdxIn == w_ridx[p])) begin
          r_rd_data[p] <= bus.WrDataIn;
          r_rd_vld[p]  <= 1'b1;
        end else begin
          r_rd_data[p] <= r_data[w_ridx[p]];
          r_rd_vld[p]  <= r_valid[w_ridx[p]] & w_idle;
        end
      end else begin
        r_rd_vld[p] <= 1'b0;
      end
    end
  end

  assign bus.Rd1DataOut   = r_rd_data[0];
  assign bus.Rd1ValidOut  = r_rd_vld[0];
  assign bus.Rd2DataOut   = r_rd_data[1];
  assign bus.Rd2ValidOut  = r_rd_vld[1];
  assign bus.RB_ValidOut  = (w_state == FLUSH) ? '0 : r_valid;
  assign bus.CountOut     = r_count;
  assign bus.BusyOut      = w_busy;
  assign bus.FlushDoneOut = w_done;
endmodule

// File: tb/tb_result_buffer.sv
// Directed bench for result_buffer with a per-cycle reference model.
module tb_result_buffer;
  import VSTypes::*;
`ifdef RB_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  result_buffer_if #(.RB_DEPTH(16), .DATA_WIDTH(32)) bus();
  result_buffer #(.RB_DEPTH(16), .DATA_WIDTH(32)) dut (
    .ClockIn(clk), .ResetIn(rst), .bus(bus)
  );

  int vectors = 0;
  int fails   = 0;
  bit chk_on  = 1'b0;

  // Reference model: entry contents, flush phase (0 idle, 1..16 flush, 17 done)
  bit            m_valid [16];
  logic [31:0]   m_data  [16];
  bit            m_dk    [16];
  int            m_phase = 0;
  RBReadRespType m_rd    [2];
  bit            m_rdk   [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] m_vec();
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++) v[i] = m_valid[i];
    if (m_phase >= 1 && m_phase <= 16) v = '0;
    return v;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  // Advance the model by one edge using the inputs present before it.
  task automatic model_step();
    bit is_idle;
    bit ren;
    int wi, ii, ri;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      m_phase = 0;
      for (int p = 0; p < 2; p++) begin m_rd[p] = '0; m_rdk[p] = 1'b1; end
      return;
    end
    is_idle = (m_phase == 0);
    wi = int'(bus.WrIdxIn);
    ii = int'(bus.InvIdxIn);
    for (int p = 0; p < 2; p++) begin
      ren = (p == 0) ? bus.rs1_RB_ReadEn : bus.rs2_RB_ReadEn;
      ri  = (p == 0) ? int'(bus.rs1_RB_IdxIn) : int'(bus.rs2_RB_IdxIn);
      if (ren) begin
        if (is_idle && BYP && bus.WrEnIn && wi == ri) begin
          m_rd[p].data = bus.WrDataIn; m_rd[p].valid = 1'b1; m_rdk[p] = 1'b1;
        end else begin
          m_rd[p].data  = m_data[ri];
          m_rdk[p]      = m_dk[ri];
          m_rd[p].valid = is_idle && m_valid[ri];
        end
      end else begin
        m_rd[p].valid = 1'b0;
      end
    end
    if (is_idle) begin
      if (bus.InvEnIn) m_valid[ii] = 1'b0;
      if (bus.WrEnIn) begin m_valid[wi] = 1'b1; m_data[wi] = bus.WrDataIn; m_dk[wi] = 1'b1; end
      if (bus.FlushReqIn) m_phase = 1;
    end else if (m_phase <= 16) begin
      m_valid[m_phase-1] = 1'b0;
      m_phase++;
    end else begin
      m_phase = 0;
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("rb_valid", 64'(bus.RB_ValidOut), 64'(m_vec()));
      chk("count",    64'(bus.CountOut),    64'(m_count()));
      chk("busy",     64'(bus.BusyOut),     64'(m_phase != 0));
      chk("done",     64'(bus.FlushDoneOut),64'(m_phase == 17));
      chk("rd1_vld",  64'(bus.Rd1ValidOut), 64'(m_rd[0].valid));
      chk("rd2_vld",  64'(bus.Rd2ValidOut), 64'(m_rd[1].valid));
      if (m_rdk[0]) chk("rd1_data", 64'(bus.Rd1DataOut), 64'(m_rd[0].data));
      if (m_rdk[1]) chk("rd2_data", 64'(bus.Rd2DataOut), 64'(m_rd[1].data));
    end
  end

  task automatic idle_in();
    bus.WrEnIn = 0; bus.WrIdxIn = '0; bus.WrDataIn = '0;
    bus.InvEnIn = 0; bus.InvIdxIn = '0;
    bus.rs1_RB_ReadEn = 0; bus.rs1_RB_IdxIn = '0;
    bus.rs2_RB_ReadEn = 0; bus.rs2_RB_IdxIn = '0;
    bus.FlushReqIn = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    bus.WrEnIn = 1; bus.WrIdxIn = 4'(idx); bus.WrDataIn = d;
  endtask

  task automatic rd(input int port, input int idx);
    if (port == 1) begin bus.rs1_RB_ReadEn = 1; bus.rs1_RB_IdxIn = 4'(idx); end
    else begin bus.rs2_RB_ReadEn = 1; bus.rs2_RB_IdxIn = 4'(idx); end
  endtask

  int busy_n, done_n, done_at;

  initial begin
    idle_in();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    chk("reset_count", 64'(bus.CountOut), 64'd0);
    chk("reset_busy",  64'(bus.BusyOut),  64'd0);
    chk("reset_rd1",   64'(bus.Rd1DataOut), 64'd0);

    // write then read
    wr(3, 32'hDEADBEEF); tick(); idle_in();
    rd(1, 3); tick(); idle_in();
    @(negedge clk);
    chk("wr_rd_data",  64'(bus.Rd1DataOut),     64'hDEADBEEF);
    chk("wr_rd_vld",   64'(bus.Rd1ValidOut),    64'd1);
    chk("wr_rd_vbit",  64'(bus.RB_ValidOut[3]), 64'd1);
    chk("wr_rd_count", 64'(bus.CountOut),       64'd1);

    // same-index write + invalidate: write wins
    wr(5, 32'h55); bus.InvEnIn = 1; bus.InvIdxIn = 4'd5; tick(); idle_in();
    @(negedge clk);
    chk("wrinv_vbit",  64'(bus.RB_ValidOut[5]), 64'd1);
    chk("wrinv_count", 64'(bus.CountOut),       64'd2);
    bus.InvEnIn = 1; bus.InvIdxIn = 4'd5; tick(); idle_in();
    @(negedge clk);
    chk("inv_count",   64'(bus.CountOut),       64'd1);

    // different-index write + invalidate, rewrite, dual read, stale read
    wr(9, 32'h99); bus.InvEnIn = 1; bus.InvIdxIn = 4'd3; tick(); idle_in();
    wr(9, 32'h999); tick(); idle_in();
    bus.InvEnIn = 1; bus.InvIdxIn = 4'd4; tick(); idle_in();
    rd(1, 9); rd(2, 9); tick(); idle_in();
    @(negedge clk);
    chk("dual_rd2",    64'(bus.Rd2DataOut), 64'h999);
    chk("mix_count",   64'(bus.CountOut),   64'd1);
    rd(1, 3); tick(); idle_in();
    @(negedge clk);
    chk("stale_vld",   64'(bus.Rd1ValidOut), 64'd0);
    chk("stale_data",  64'(bus.Rd1DataOut),  64'hDEADBEEF);
    tick();

    // same-cycle write and read
    wr(7, 32'hAAAA); tick(); idle_in();
    wr(7, 32'h1234); rd(1, 7); rd(2, 7); tick(); idle_in();
    @(negedge clk);
    chk("byp_data", 64'(bus.Rd1DataOut), BYP ? 64'h1234 : 64'hAAAA);
    chk("byp_vld",  64'(bus.Rd1ValidOut), 64'd1);
    rd(1, 7); tick(); idle_in();

    // fill all entries, then flush with writes/reads/requests during it
    for (int i = 0; i < 16; i++) begin wr(i, 32'h1000 + 32'(i)); tick(); end
    idle_in();
    @(negedge clk);
    chk("full_count", 64'(bus.CountOut), 64'd16);
    bus.FlushReqIn = 1; tick(); idle_in();
    busy_n = 0; done_n = 0; done_at = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i <= 17) begin
        wr(i % 16, 32'hBAD0000 + 32'(i)); rd(1, i % 16); bus.FlushReqIn = 1;
      end else idle_in();
      @(negedge clk);
      if (bus.BusyOut) busy_n++;
      if (bus.FlushDoneOut) begin done_n++; if (done_at == 0) done_at = i; end
      tick();
    end
    idle_in();
    @(negedge clk);
    chk("flush_busy_cycles", 64'(busy_n),  64'd17);
    chk("flush_done_cycle",  64'(done_at), 64'd17);
    chk("flush_done_pulses", 64'(done_n),  64'd1);
    chk("flush_count",       64'(bus.CountOut),    64'd0);
    chk("flush_vvec",        64'(bus.RB_ValidOut), 64'd0);

    // reset in the middle of a flush
    wr(2, 32'h22); tick(); wr(11, 32'hBB); tick(); idle_in();
    bus.FlushReqIn = 1; tick(); idle_in();
    repeat (8) tick();
    @(negedge clk);
    chk("midflush_busy", 64'(bus.BusyOut), 64'd1);
    rst = 1'b1; wr(4, 32'h44); rd(1, 2); tick(); rst = 1'b0; idle_in();
    @(negedge clk);
    chk("rst_busy",  64'(bus.BusyOut),     64'd0);
    chk("rst_count", 64'(bus.CountOut),    64'd0);
    chk("rst_vvec",  64'(bus.RB_ValidOut), 64'd0);
    chk("rst_rd1",   64'(bus.Rd1DataOut),  64'd0);
    wr(0, 32'hCAFE0000); tick(); idle_in();
    rd(1, 0); tick(); idle_in();
    @(negedge clk);
    chk("post_rst_data",  64'(bus.Rd1DataOut),  64'hCAFE0000);
    chk("post_rst_vld",   64'(bus.Rd1ValidOut), 64'd1);
    chk("post_rst_count", 64'(bus.CountOut),    64'd1);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/result_buffer.md
RESULT_BUFFER -- requirements
Module: result_buffer

Interface
REQ-001 SHALL have parameter RB_DEPTH, default 16: number of result-buffer entries (power of two).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of one stored result.
REQ-003 SHALL have port ClockIn, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port ResetIn, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports WrEnIn (in, 1), WrIdxIn (in, 4) and WrDataIn (in, 32): writeback of a reusable result.
REQ-006 SHALL have ports InvEnIn (in, 1) and InvIdxIn (in, 4): invalidate one entry.
REQ-007 SHALL have ports rs1_RB_ReadEn (in, 1) and rs1_RB_IdxIn (in, 4): read port 1, driven by the fetch skip logic.
REQ-008 SHALL have ports rs2_RB_ReadEn (in, 1) and rs2_RB_IdxIn (in, 4): read port 2.
REQ-009 SHALL have ports Rd1DataOut (out, 32) and Rd1ValidOut (out, 1), plus Rd2DataOut (out, 32) and Rd2ValidOut (out, 1): registered read results.
REQ-010 SHALL have port RB_ValidOut, out, 16: per-entry valid vector, consumed as RB_ValidIn by fetch.
REQ-011 SHALL have ports FlushReqIn (in, 1), BusyOut (out, 1) and FlushDoneOut (out, 1): flush handshake.
REQ-012 SHALL have port CountOut, out, 5: number of valid entries, range 0..16.

Function
REQ-013 SHALL, on WrEnIn=1 outside FLUSH, load Data[WrIdxIn] <= WrDataIn and set Valid[WrIdxIn] <= 1 at the next edge.
REQ-014 SHALL, on InvEnIn=1 outside FLUSH, clear Valid[InvIdxIn] at the next edge; data is retained.
REQ-015 SHALL let write win when a write and an invalidate target the same index in the same cycle, leaving the entry valid.
REQ-016 SHALL give each read port one-cycle latency: when ReadEn=1 in cycle N, RdxDataOut/RdxValidOut in cycle N+1 reflect Data/Valid as they stood before the edge.
REQ-017 SHALL, when ReadEn=0, drive RdxValidOut=0 in the next cycle and hold RdxDataOut at its previous value.
REQ-018 SHALL let both read ports address the same index in the same cycle, each returning identical results.
REQ-019 SHALL drive RB_ValidOut combinationally from the Valid registers, and force it to all-zero while in FLUSH.
REQ-020 SHALL maintain CountOut as a register updated every edge, with the following rules:
  - +1 on a write to an invalid entry;
  - -1 on an invalidate of a valid entry, except when a same-index write wins per REQ-015;
  - no change on a rewrite of an already-valid entry;
  - no wrap past 16 or below 0;
  - a write and an invalidate to different indices in one cycle are applied independently.
REQ-021 SHALL implement FSM states IDLE, FLUSH and DONE, with these transitions:
  - IDLE -> FLUSH on FlushReqIn=1;
  - FLUSH clears Valid[cnt] each cycle while a 4-bit counter cnt steps 0..15;
  - FLUSH -> DONE after cnt=15;
  - DONE -> IDLE unconditionally.
REQ-022 SHALL assert BusyOut=1 in FLUSH and DONE, and assert FlushDoneOut=1 only in DONE, for exactly one cycle.
REQ-023 SHALL, in FLUSH and DONE, ignore writes, invalidates and FlushReqIn, and return RdxValidOut=0 for reads.
REQ-024 SHALL reach CountOut=0 on entry to DONE; a flush therefore takes 16 FLUSH cycles plus 1 DONE cycle.

Reset
REQ-025 SHALL, while ResetIn=1 at an edge, set the following, taking priority over all other inputs including mid-flush:
  - state=IDLE, cnt=0;
  - all Valid=0, CountOut=0;
  - Rd1/Rd2 Data and Valid outputs = 0;
  - BusyOut=0, FlushDoneOut=0.
REQ-026 SHALL leave Data array contents undefined after reset; contents are never observable while Valid=0 except via RdxDataOut.

Configuration
REQ-027 SHALL, with macro RB_WR_BYPASS_EN defined, forward a same-cycle write to a read of the same index (outside FLUSH): next-cycle RdxDataOut=WrDataIn and RdxValidOut=1.
REQ-028 SHALL, without RB_WR_BYPASS_EN, apply REQ-016 strictly, so a same-cycle read returns the pre-write entry.

Structure
REQ-029 SHALL place RB_SIZE (16), RB_IDX_W (4), RBStateType (IDLE, FLUSH, DONE) and RBReadRespType (data, valid) in package VSTypes.
REQ-030 SHALL implement the FSM and counter as sub-module rb_flush_ctrl (outputs: state, cnt, clear-enable); the storage array remains in result_buffer.

Verification
REQ-031 SHALL cover write then read: write idx 3 = 0xDEADBEEF, read rs1 idx 3 next cycle -> Rd1DataOut=0xDEADBEEF, Rd1ValidOut=1, RB_ValidOut[3]=1, CountOut=1.
REQ-032 SHALL cover simultaneous write and invalidate: write and invalidate idx 5 in one cycle with 5 invalid -> Valid[5]=1, CountOut increments by 1; invalidate idx 5 alone -> CountOut decrements by 1.
REQ-033 SHALL cover flush: fill all 16 entries (CountOut=16), pulse FlushReqIn -> BusyOut high for 17 cycles, FlushDoneOut on the 17th, RB_ValidOut=0, CountOut=0, writes during flush dropped.
REQ-034 SHALL cover same-cycle write and read: write idx 7 = 0x1234 while reading idx 7 (previously 0xAAAA, valid) -> with RB_WR_BYPASS_EN the read returns 0x1234; without it, 0xAAAA.
REQ-035 SHALL cover reset mid-flush: assert ResetIn at cnt=8 -> next cycle state=IDLE, BusyOut=0, all outputs 0; a subsequent write and read of idx 0 works normally.
